// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    // Address width for a register count; a 2-entry file still needs one bit.
    function automatic int addrWidth(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result tracker: one busy flop per register, set by issue,
// cleared by either write port, with issue taking priority over clear.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = addrWidth(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite0,
    input  logic [AW-1:0]     WriteAddr0,
    input  logic              RegWrite1,
    input  logic [AW-1:0]     WriteAddr1,
    input  logic              IssueValid,
    input  logic [AW-1:0]     IssueAddr,
    input  logic [NRD*AW-1:0] ReadAddr,
    output logic [NRD-1:0]    ReadBusy
);

    logic [NREG-1:0] busy;

    // Busy flops: a fresh issue wins over a completing write to the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (IssueValid && (IssueAddr == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((RegWrite0 && (WriteAddr0 == AW'(i))) ||
                             (RegWrite1 && (WriteAddr1 == AW'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : gLookup
        logic [AW-1:0] addr;
        logic          writtenNow;
        logic          issuedNow;

        assign addr       = ReadAddr[k*AW +: AW];
        assign writtenNow = (RegWrite0 && (WriteAddr0 == addr)) ||
                            (RegWrite1 && (WriteAddr1 == addr));
        assign issuedNow  = IssueValid && (IssueAddr == addr);

        // Per-port busy lookup; a completing write hides busy early when forwarding.
        always_comb begin
            ReadBusy[k] = busy[addr];
            if ((BYPASS != 0) && writtenNow && !issuedNow) begin
                ReadBusy[k] = 1'b0;
            end
            if (reset || (addr == '0)) begin
                ReadBusy[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/registers_mp.sv
// Two-write, NRD-read register file with optional write-to-read forwarding
// and a per-register pending-result scoreboard. Register 0 is hardwired to 0.
module registers_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = addrWidth(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite0,
    input  logic [AW-1:0]       WriteAddr0,
    input  logic [XLEN-1:0]     WriteData0,
    input  logic                RegWrite1,
    input  logic [AW-1:0]       WriteAddr1,
    input  logic [XLEN-1:0]     WriteData1,
    input  logic                IssueValid,
    input  logic [AW-1:0]       IssueAddr,
    input  logic [NRD*AW-1:0]   ReadAddr,
    output logic [NRD*XLEN-1:0] ReadData,
    output logic [NRD-1:0]      ReadBusy
);

    logic [XLEN-1:0] regs [NREG];

    // Data array: port 1 overrides port 0 on an address collision; entry 0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (RegWrite1 && (WriteAddr1 == AW'(i))) begin
                    regs[i] <= WriteData1;
                end else if (RegWrite0 && (WriteAddr0 == AW'(i))) begin
                    regs[i] <= WriteData0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : gRead
        logic [AW-1:0] addr;
        logic          hit0;
        logic          hit1;

        assign addr = ReadAddr[k*AW +: AW];
        assign hit0 = RegWrite0 && (WriteAddr0 == addr);
        assign hit1 = RegWrite1 && (WriteAddr1 == addr);

        // Combinational read with forwarding of the winning write data; forced to 0 for R0 and reset.
        always_comb begin
            ReadData[k*XLEN +: XLEN] = regs[addr];
            if (BYPASS != 0) begin
                if (hit1) begin
                    ReadData[k*XLEN +: XLEN] = WriteData1;
                end else if (hit0) begin
                    ReadData[k*XLEN +: XLEN] = WriteData0;
                end
            end
            if (reset || (addr == '0)) begin
                ReadData[k*XLEN +: XLEN] = '0;
            end
        end
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) uScoreboard (
        .clk        (clk),
        .reset      (reset),
        .RegWrite0  (RegWrite0),
        .WriteAddr0 (WriteAddr0),
        .RegWrite1  (RegWrite1),
        .WriteAddr1 (WriteAddr1),
        .IssueValid (IssueValid),
        .IssueAddr  (IssueAddr),
        .ReadAddr   (ReadAddr),
        .ReadBusy   (ReadBusy)
    );

endmodule

// File: tb/tb_registers_mp.sv
// Bench for registers_mp: a default build (32x32, 2 reads, forwarding) and a
// 16x64, 4-read build without forwarding, both checked against array models.
module tb_registers_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u0: XLEN=32, NREG=32, NRD=2, BYPASS=1
    logic        rw0, rw1, iv;
    logic [4:0]  wa0, wa1, ia;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra0;
    logic [63:0] rd0;
    logic [1:0]  rb0;

    // u1: XLEN=64, NREG=16, NRD=4, BYPASS=0
    logic         rw0b, rw1b, ivb;
    logic [3:0]   wa0b, wa1b, iab;
    logic [63:0]  wd0b, wd1b;
    logic [15:0]  ra1;
    logic [255:0] rd1;
    logic [3:0]   rb1;

    registers_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset),
        .RegWrite0(rw0), .WriteAddr0(wa0), .WriteData0(wd0),
        .RegWrite1(rw1), .WriteAddr1(wa1), .WriteData1(wd1),
        .IssueValid(iv), .IssueAddr(ia),
        .ReadAddr(ra0), .ReadData(rd0), .ReadBusy(rb0)
    );

    registers_mp #(.XLEN(64), .NREG(16), .NRD(4), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset),
        .RegWrite0(rw0b), .WriteAddr0(wa0b), .WriteData0(wd0b),
        .RegWrite1(rw1b), .WriteAddr1(wa1b), .WriteData1(wd1b),
        .IssueValid(ivb), .IssueAddr(iab),
        .ReadAddr(ra1), .ReadData(rd1), .ReadBusy(rb1)
    );

    typedef struct {
        int          dut;
        bit          isBusy;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    // Reference state: architectural contents and pending flags.
    logic [31:0] m0 [32];
    bit          p0 [32];
    logic [63:0] m1 [16];
    bit          p1 [16];

    // Monitor: at each falling edge compare everything queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] act;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.dut == 0)
                act = e.isBusy ? 64'(rb0[e.port]) : 64'(rd0[e.port*32 +: 32]);
            else
                act = e.isBusy ? 64'(rb1[e.port]) : rd1[e.port*64 +: 64];
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s port=%0d got=%h want=%h t=%0t", e.name, e.port, act, e.exp, $time);
            end
        end
    end

    task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    initial begin
        #1000000;
        checks++;
        failures++;
        $display("FAIL timeout waiting for stimulus to finish t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic pushExp();
        logic [63:0] v;
        bit b, wr, is;
        int a;
        for (int k = 0; k < 2; k++) begin
            a  = int'(ra0[k*5 +: 5]);
            wr = (rw0 && int'(wa0) == a) || (rw1 && int'(wa1) == a);
            is = iv && int'(ia) == a;
            v  = 64'(m0[a]);
            if (rw1 && int'(wa1) == a) v = 64'(wd1);
            else if (rw0 && int'(wa0) == a) v = 64'(wd0);
            b  = p0[a] && !(wr && !is);
            if (reset || a == 0) begin v = 0; b = 0; end
            sbq.push_back('{0, 1'b0, k, v, "u0_data"});
            sbq.push_back('{0, 1'b1, k, 64'(b), "u0_busy"});
        end
        for (int k = 0; k < 4; k++) begin
            a = int'(ra1[k*4 +: 4]);
            v = m1[a];
            b = p1[a];
            if (reset || a == 0) begin v = 0; b = 0; end
            sbq.push_back('{1, 1'b0, k, v, "u1_data"});
            sbq.push_back('{1, 1'b1, k, 64'(b), "u1_busy"});
        end
    endtask

    // One cycle: queue expectations, let the edge happen, advance the model, drive after the edge.
    task automatic step();
        pushExp();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m0[i] = 0; p0[i] = 0; end
            for (int i = 0; i < 16; i++) begin m1[i] = 0; p1[i] = 0; end
        end else begin
            if (rw0 && wa0 != 0) begin m0[wa0] = wd0; p0[wa0] = 0; end
            if (rw1 && wa1 != 0) begin m0[wa1] = wd1; p0[wa1] = 0; end
            if (iv && ia != 0) p0[ia] = 1;
            if (rw0b && wa0b != 0) begin m1[wa0b] = wd0b; p1[wa0b] = 0; end
            if (rw1b && wa1b != 0) begin m1[wa1b] = wd1b; p1[wa1b] = 0; end
            if (ivb && iab != 0) p1[iab] = 1;
        end
        #1;
    endtask

    task automatic idle();
        rw0 = 0; rw1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iv = 0; ia = 0; ra0 = 0;
        rw0b = 0; rw1b = 0; wa0b = 0; wa1b = 0; wd0b = 0; wd1b = 0; ivb = 0; iab = 0; ra1 = 0;
    endtask

    function automatic logic [4:0] pick5();
        return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [3:0] pick4();
        return ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    task automatic randomize_inputs();
        rw0 = 1'($urandom_range(0, 1)); wa0 = pick5(); wd0 = $urandom;
        rw1 = 1'($urandom_range(0, 1)); wa1 = pick5(); wd1 = $urandom;
        iv  = ($urandom_range(0, 2) == 0); ia = pick5();
        ra0 = {pick5(), pick5()};
        rw0b = 1'($urandom_range(0, 1)); wa0b = pick4(); wd0b = {$urandom, $urandom};
        rw1b = 1'($urandom_range(0, 1)); wa1b = pick4(); wd1b = {$urandom, $urandom};
        ivb  = ($urandom_range(0, 2) == 0); iab = pick4();
        ra1  = {pick4(), pick4(), pick4(), pick4()};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m0[i] = 0; p0[i] = 0; end
        for (int i = 0; i < 16; i++) begin m1[i] = 0; p1[i] = 0; end
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        check_eq("reset_state_u0", {128'd0, rd0, 62'd0, rb0}, 256'd0);
        check_eq("reset_state_u1_data", rd1, 256'd0);
        check_eq("reset_state_u1_busy", 256'(rb1), 256'd0);
        // reset state, with writes presented that must be discarded
        ra0 = {5'd3, 5'd1}; ra1 = {4'd4, 4'd3, 4'd2, 4'd1};
        rw0 = 1; wa0 = 5'd1; wd0 = 32'hFFFF0001; iv = 1; ia = 5'd3;
        step();
        #2 reset = 1'b0;
        idle();
        ra0 = {5'd3, 5'd1}; ra1 = {4'd4, 4'd3, 4'd2, 4'd1};
        step();

        // write R5 via port 0, then read R5 and R10
        idle(); rw0 = 1; wa0 = 5'd5; wd0 = 32'hAAAAAAAA; ra0 = {5'd10, 5'd5};
        step();
        idle(); ra0 = {5'd10, 5'd5};
        step();

        // R0 ignores writes on both ports and issues
        idle(); rw0 = 1; rw1 = 1; wa0 = 0; wa1 = 0; wd0 = 32'hDEADBEEF; wd1 = 32'hDEADBEEF;
        iv = 1; ia = 0; ra0 = {5'd0, 5'd0};
        step();
        idle(); ra0 = {5'd0, 5'd0};
        step();

        // colliding writes to R7: port 1 wins; u1 (no forwarding) shows old value this cycle
        idle(); rw0 = 1; wa0 = 5'd7; wd0 = 32'h11111111; rw1 = 1; wa1 = 5'd7; wd1 = 32'h22222222;
        ra0 = {5'd5, 5'd7};
        rw0b = 1; wa0b = 4'd7; wd0b = 64'h1111111111111111; rw1b = 1; wa1b = 4'd7; wd1b = 64'h2222222222222222;
        ra1 = {4'd0, 4'd0, 4'd0, 4'd7};
        step();
        idle(); ra0 = {5'd5, 5'd7}; ra1 = {4'd0, 4'd0, 4'd0, 4'd7};
        step();

        // scoreboard on R3: issue, write-clear, issue+write together
        idle(); iv = 1; ia = 5'd3; ra0 = {5'd0, 5'd3}; ivb = 1; iab = 4'd3; ra1 = {12'd0, 4'd3};
        step();
        idle(); ra0 = {5'd0, 5'd3}; ra1 = {12'd0, 4'd3};
        step();
        idle(); rw0 = 1; wa0 = 5'd3; wd0 = 32'h5; ra0 = {5'd0, 5'd3};
        rw0b = 1; wa0b = 4'd3; wd0b = 64'h5; ra1 = {12'd0, 4'd3};
        step();
        idle(); ra0 = {5'd0, 5'd3}; ra1 = {12'd0, 4'd3};
        step();
        idle(); iv = 1; ia = 5'd3; rw1 = 1; wa1 = 5'd3; wd1 = 32'h6; ra0 = {5'd3, 5'd3};
        ivb = 1; iab = 4'd3; rw1b = 1; wa1b = 4'd3; wd1b = 64'h6; ra1 = {12'd0, 4'd3};
        step();
        idle(); ra0 = {5'd0, 5'd3}; ra1 = {12'd0, 4'd3};
        step();

        // fill with index values, then reset mid-cycle
        for (int i = 1; i < 32; i++) begin
            idle(); rw0 = 1; wa0 = 5'(i); wd0 = 32'(i); ra0 = {5'(i), 5'(i - 1)};
            if (i < 16) begin rw0b = 1; wa0b = 4'(i); wd0b = 64'(i) * 64'h0001000100010001; end
            ra1 = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(i - 1)};
            step();
        end
        idle(); ra0 = {5'd31, 5'd4}; ra1 = {4'd15, 4'd9, 4'd4, 4'd1};
        step();
        idle(); ra0 = {5'd31, 5'd4}; ra1 = {4'd15, 4'd9, 4'd4, 4'd1};
        #2 reset = 1'b1;
        rw0 = 1; wa0 = 5'd9; wd0 = 32'hFFFFFFFF; iv = 1; ia = 5'd9;
        rw0b = 1; wa0b = 4'd9; wd0b = '1; ivb = 1; iab = 4'd9;
        #1;
        check_eq("midcycle_reset_u0", {128'd0, rd0, 62'd0, rb0}, 256'd0);
        check_eq("midcycle_reset_u1_data", rd1, 256'd0);
        check_eq("midcycle_reset_u1_busy", 256'(rb1), 256'd0);
        step();
        #2 reset = 1'b0;
        idle(); rw0 = 1; wa0 = 5'd4; wd0 = 32'h00001234; ra0 = {5'd9, 5'd4};
        rw0b = 1; wa0b = 4'd4; wd0b = 64'h1234; ra1 = {4'd15, 4'd9, 4'd4, 4'd1};
        step();
        idle(); ra0 = {5'd9, 5'd4}; ra1 = {4'd15, 4'd9, 4'd4, 4'd1};
        step();

        // four distinct concurrent 64-bit reads on u1
        idle(); rw0b = 1; wa0b = 4'd1; wd0b = 64'h0123456789ABCDEF; rw1b = 1; wa1b = 4'd2; wd1b = 64'hFEDCBA9876543210;
        step();
        idle(); rw0b = 1; wa0b = 4'd3; wd0b = 64'hA5A5A5A55A5A5A5A; rw1b = 1; wa1b = 4'd14; wd1b = 64'h8000000000000001;
        step();
        idle(); ra1 = {4'd14, 4'd3, 4'd2, 4'd1};
        step();

        // randomized traffic on both builds
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            step();
        end

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
